vga_wb_char_writer: RTL

- Wishbone B3 classic single-access initiator that drives the VGA character peripheral's register map from a simple command interface.
- Each accepted command (row, column, ASCII code) becomes a fixed sequence:
  - write the position register;
  - write the character register;
  - when VERIFY=1, read both back and compare.
- Sits between the CPU-side/test logic and the VGA peripheral's Wishbone slave port, in the wb_clk_i domain. Reports completion and error status per command.

---
 rtl/vga_wb_char_writer.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/vga_wb_char_writer.sv
// vga_wb_char_writer: Wishbone B3 classic single-access initiator that turns a
// (row, col, char) command into position/character register writes on the
// VGA character peripheral, optionally followed by a readback and compare.
// All bus outputs are registered; each access ends on the first edge that
// samples ack or err with stb high, so a slave that holds ack is not
// double-counted.
module vga_wb_char_writer #(
  parameter bit          VERIFY         = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [7:0]  POS_WR_ADR     = 8'h00,
  parameter logic [7:0]  CHR_WR_ADR     = 8'h0C,
  parameter logic [7:0]  POS_RD_ADR     = 8'h04,
  parameter logic [7:0]  CHR_RD_ADR     = 8'h08
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [9:0]  cmd_row,
  input  logic [9:0]  cmd_col,
  input  logic [7:0]  cmd_char,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [7:0]  wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  output logic        done_o,
  output logic [2:0]  status_o,
  output logic        busy_o
);

  // Last count value before an unanswered strobe is declared timed out.
  localparam logic [7:0] LP_TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_POS,
    S_GAP1,
    S_WR_CHR,
    S_GAP2,
    S_RD_POS,
    S_GAP3,
    S_RD_CHR,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  // Latched command fields.
  logic [9:0]  r_row;
  logic [9:0]  r_col;
  logic [7:0]  r_char;

  // Cycles spent with stb high in the current access.
  logic [7:0]  r_tmo_cnt;

  // Status bits: {timeout, bus_err, mismatch}.
  logic [2:0]  r_status;
  logic [2:0]  w_status_nxt;

  // Registered outputs.
  logic        r_cyc;
  logic        r_stb;
  logic        r_we;
  logic [7:0]  r_adr;
  logic [31:0] r_dat;
  logic        r_done;
  logic        r_busy;
  logic        r_ready;

  // Next values of the registered bus outputs.
  logic        w_cyc_nxt;
  logic        w_stb_nxt;
  logic        w_we_nxt;
  logic [7:0]  w_adr_nxt;
  logic [31:0] w_dat_nxt;

  logic        w_accept;
  logic        w_ack;
  logic        w_err;
  logic        w_tmo;
  logic [31:0] w_pos_word;
  logic [31:0] w_chr_word;

  assign w_accept = cmd_valid & r_ready;

  // err outranks ack on the same edge; both only count while stb is high.
  assign w_err = r_stb & wb_err_i;
  assign w_ack = r_stb & wb_ack_i & ~wb_err_i;
  assign w_tmo = r_stb & ~wb_ack_i & ~wb_err_i & (r_tmo_cnt == LP_TMO_LAST);

  // On the accept edge the latches are not yet loaded, so take the inputs.
  assign w_pos_word = w_accept ? {12'b0, cmd_row, cmd_col} : {12'b0, r_row, r_col};
  assign w_chr_word = w_accept ? {24'b0, cmd_char} : {24'b0, r_char};

  // Next-state and status update: access sequencing, abort and compare.
  always_comb begin
    w_state_nxt  = r_state;
    w_status_nxt = r_status;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt  = S_WR_POS;
          w_status_nxt = 3'b000;
        end
      end
      S_WR_POS, S_WR_CHR, S_RD_POS, S_RD_CHR: begin
        if (w_err) begin
          w_state_nxt     = S_DONE;
          w_status_nxt[1] = 1'b1;
        end else if (w_ack) begin
          case (r_state)
            S_WR_POS: w_state_nxt = S_GAP1;
            S_WR_CHR: begin
              if (VERIFY) w_state_nxt = S_GAP2;
              else        w_state_nxt = S_DONE;
            end
            S_RD_POS: begin
              w_state_nxt = S_GAP3;
              if (wb_dat_i != w_pos_word) w_status_nxt[0] = 1'b1;
            end
            default: begin
              w_state_nxt = S_DONE;
              if (wb_dat_i != w_chr_word) w_status_nxt[0] = 1'b1;
            end
          endcase
        end else if (w_tmo) begin
          w_state_nxt     = S_DONE;
          w_status_nxt[2] = 1'b1;
        end
      end
      S_GAP1:  w_state_nxt = S_WR_CHR;
      S_GAP2:  w_state_nxt = S_RD_POS;
      S_GAP3:  w_state_nxt = S_RD_CHR;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Bus output decode from the state being entered, so outputs are registered.
  always_comb begin
    w_cyc_nxt = 1'b0;
    w_stb_nxt = 1'b0;
    w_we_nxt  = 1'b0;
    w_adr_nxt = 8'h00;
    w_dat_nxt = 32'h0;
    case (w_state_nxt)
      S_WR_POS: begin
        w_cyc_nxt = 1'b1;
        w_stb_nxt = 1'b1;
        w_we_nxt  = 1'b1;
        w_adr_nxt = POS_WR_ADR;
        w_dat_nxt = w_pos_word;
      end
      S_WR_CHR: begin
        w_cyc_nxt = 1'b1;
        w_stb_nxt = 1'b1;
        w_we_nxt  = 1'b1;
        w_adr_nxt = CHR_WR_ADR;
        w_dat_nxt = w_chr_word;
      end
      S_RD_POS: begin
        w_cyc_nxt = 1'b1;
        w_stb_nxt = 1'b1;
        w_adr_nxt = POS_RD_ADR;
      end
      S_RD_CHR: begin
        w_cyc_nxt = 1'b1;
        w_stb_nxt = 1'b1;
        w_adr_nxt = CHR_RD_ADR;
      end
      S_GAP1, S_GAP2, S_GAP3: begin
        w_cyc_nxt = 1'b1;
      end
      default: begin
        w_cyc_nxt = 1'b0;
      end
    endcase
  end

  // State register and registered outputs; reset aborts any bus cycle at once.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state  <= S_IDLE;
      r_status <= 3'b000;
      r_cyc    <= 1'b0;
      r_stb    <= 1'b0;
      r_we     <= 1'b0;
      r_adr    <= 8'h00;
      r_dat    <= 32'h0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
      r_ready  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_status <= w_status_nxt;
      r_cyc    <= w_cyc_nxt;
      r_stb    <= w_stb_nxt;
      r_we     <= w_we_nxt;
      r_adr    <= w_adr_nxt;
      r_dat    <= w_dat_nxt;
      r_done   <= (w_state_nxt == S_DONE);
      r_busy   <= (w_state_nxt != S_IDLE);
      r_ready  <= (w_state_nxt == S_IDLE);
    end
  end

  // Command latch: loaded only on accept so later input changes are ignored.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_row  <= 10'd0;
      r_col  <= 10'd0;
      r_char <= 8'd0;
    end else if (w_accept) begin
      r_row  <= cmd_row;
      r_col  <= cmd_col;
      r_char <= cmd_char;
    end
  end

  // Timeout counter: cleared on entry to each access, counts unanswered stb cycles.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_tmo_cnt <= 8'd0;
    end else if (w_stb_nxt && (w_state_nxt != r_state)) begin
      r_tmo_cnt <= 8'd0;
    end else if (r_stb) begin
      r_tmo_cnt <= r_tmo_cnt + 8'd1;
    end else begin
      r_tmo_cnt <= 8'd0;
    end
  end

  assign cmd_ready = r_ready;
  assign wb_cyc_o  = r_cyc;
  assign wb_stb_o  = r_stb;
  assign wb_we_o   = r_we;
  assign wb_adr_o  = r_adr;
  assign wb_dat_o  = r_dat;
  assign wb_sel_o  = {4{r_stb}};
  assign done_o    = r_done;
  assign status_o  = r_status;
  assign busy_o    = r_busy;

endmodule
